// File: rtl/spi_slave_if.sv
// Signal bundle between an SPI master and the spi_slave frame decoder.
// The slave modport is used by the design; the master modport is used by whatever drives the bus.
interface spi_slave_if #(
  parameter int unsigned ADDR_SIZE = 8
) ();
  logic                   SS_n;
  logic                   MOSI;
  logic                   MISO;
  logic [ADDR_SIZE+1:0]   rx_data;
  logic                   rx_valid;
  logic [ADDR_SIZE-1:0]   tx_data;
  logic                   tx_valid;

  modport slave (
    input  SS_n,
    input  MOSI,
    output MISO,
    output rx_data,
    output rx_valid,
    input  tx_data,
    input  tx_valid
  );

  modport master (
    output SS_n,
    output MOSI,
    input  MISO,
    input  rx_data,
    input  rx_valid,
    output tx_data,
    output tx_valid
  );
endinterface

// File: rtl/spi_slave.sv
// SPI slave frame decoder: collects {cmd[1:0], payload} frames into rx_data and,
// for read-data frames, shifts the returned tx_data out on MISO MSB-first.
module spi_slave #(
  parameter int unsigned ADDR_SIZE = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  spi_slave_if.slave bus
);

  localparam int unsigned FrameW  = ADDR_SIZE + 2;
  localparam int unsigned CntW    = $clog2(ADDR_SIZE + 2);
  localparam int unsigned TxCntW  = $clog2(ADDR_SIZE + 1);

  typedef enum logic [2:0] {
    StIdle     = 3'd0,
    StChkCmd   = 3'd1,
    StWrite    = 3'd2,
    StReadAdd  = 3'd3,
    StReadData = 3'd4
  } state_e;

  state_e                state_q;
  logic [CntW-1:0]       cnt_q;
  logic [FrameW-1:0]     rx_shreg_q;
  logic [FrameW-1:0]     rx_data_q;
  logic                  rx_valid_q;
  logic [ADDR_SIZE-1:0]  tx_shreg_q;
  logic [TxCntW-1:0]     tx_cnt_q;
  logic                  tx_done_q;
  logic                  miso_q;
  logic                  rd_addr_seen_q;

  logic [FrameW-1:0]     rx_shift;
  logic                  frame_done;
  logic                  tx_valid_hi;

  always_comb begin
    rx_shift    = {rx_shreg_q[FrameW-2:0], bus.MOSI};
    frame_done  = (cnt_q == CntW'(ADDR_SIZE + 1));
    // Only a clean 1 counts; X/Z on tx_valid must not start a transfer.
    tx_valid_hi = (bus.tx_valid === 1'b1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= StIdle;
      cnt_q          <= '0;
      rx_shreg_q     <= '0;
      rx_data_q      <= '0;
      rx_valid_q     <= 1'b0;
      tx_shreg_q     <= '0;
      tx_cnt_q       <= '0;
      tx_done_q      <= 1'b0;
      miso_q         <= 1'b0;
      rd_addr_seen_q <= 1'b0;
    end else begin
      rx_valid_q <= 1'b0;
      if (state_q != StIdle && bus.SS_n) begin
        // Abort or normal end of window; rd_addr_seen is deliberately left alone.
        state_q    <= StIdle;
        cnt_q      <= '0;
        tx_shreg_q <= '0;
        tx_cnt_q   <= '0;
        tx_done_q  <= 1'b0;
        miso_q     <= 1'b0;
      end else begin
        unique case (state_q)
          StIdle: begin
            cnt_q <= '0;
            if (!bus.SS_n) state_q <= StChkCmd;
          end
          StChkCmd: begin
            rx_shreg_q <= rx_shift;
            cnt_q      <= '0;
            tx_done_q  <= 1'b0;
            if (!bus.MOSI)          state_q <= StWrite;
            else if (rd_addr_seen_q) state_q <= StReadData;
            else                     state_q <= StReadAdd;
          end
          StWrite, StReadAdd, StReadData: begin
            // Counter saturates at ADDR_SIZE+1 so trailing bits never start a new frame.
            if (!frame_done) begin
              rx_shreg_q <= rx_shift;
              cnt_q      <= cnt_q + 1'b1;
              if (cnt_q == CntW'(ADDR_SIZE)) begin
                rx_data_q  <= rx_shift;
                rx_valid_q <= 1'b1;
                if (state_q == StReadAdd) rd_addr_seen_q <= 1'b1;
              end
            end
            if (state_q == StReadData) begin
              if (tx_cnt_q != '0) begin
                miso_q     <= tx_shreg_q[ADDR_SIZE-1];
                tx_shreg_q <= {tx_shreg_q[ADDR_SIZE-2:0], 1'b0};
                tx_cnt_q   <= tx_cnt_q - 1'b1;
                if (tx_cnt_q == TxCntW'(1)) begin
                  rd_addr_seen_q <= 1'b0;
                  tx_done_q      <= 1'b1;
                end
              end else begin
                miso_q <= 1'b0;
                if (frame_done && !tx_done_q && tx_valid_hi) begin
                  tx_shreg_q <= bus.tx_data;
                  tx_cnt_q   <= TxCntW'(ADDR_SIZE);
                end
              end
            end
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

  assign bus.MISO     = miso_q;
  assign bus.rx_data  = rx_data_q;
  assign bus.rx_valid = rx_valid_q;

endmodule
